// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and parity helpers.
// The receive side imports the same package so both directions agree on encodings.
package uart_tx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int DEFAULT_CLKS_PER_BAUD = 868;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

   // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BAUD-1 and flags the terminal count and the cycle before it.
module uart_baud_gen
   import uart_tx_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD
) (
   input  logic i_clk,
   input  logic i_reset_w,
   input  logic i_restart_w,
   output logic o_tick_w,
   output logic o_pre_tick_w
);

   localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BAUD - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BAUD - 2);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (i_restart_w || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset_w) begin
      if (i_reset_w) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick_w     = (cnt_q == LAST);
   assign o_pre_tick_w = (cnt_q == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from a first-word-fall-through FIFO and
// serialises start / data (LSB first) / optional parity / stop onto o_tx_w.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD,
   parameter int DATA_BITS     = 8,
   parameter int PARITY_EN     = 0,
   parameter int PARITY_ODD    = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_w,
   input  logic                 i_enable_w,
   input  logic [DATA_BITS-1:0] i_fifo_data_w,
   input  logic                 i_fifo_empty_w,
   output logic                 o_fifo_read_w,
   output logic                 o_tx_w,
   output logic                 o_busy_w,
   output logic                 o_frame_done_w
);

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

   tx_state_e            state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 parity_q;
   logic [BW-1:0]        bit_cnt_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 done_q;

   logic baud_restart;
   logic tick;
   logic pre_tick;
   logic can_pop;
   logic last_stop;
   logic pop;

   // The counter is held at zero while idle so the start bit gets a full period.
   assign baud_restart = (state_q == ST_IDLE);

   uart_baud_gen #(
      .CLKS_PER_BAUD(CLKS_PER_BAUD)
   ) u_baud (
      .i_clk       (i_clk),
      .i_reset_w   (i_reset_w),
      .i_restart_w (baud_restart),
      .o_tick_w    (tick),
      .o_pre_tick_w(pre_tick)
   );

   // Pops happen from idle or in the final stop cycle; reset blocks them so no byte
   // leaves the FIFO while the sequencer is held.
   assign can_pop   = i_enable_w && !i_fifo_empty_w && !i_reset_w;
   assign last_stop = (bit_cnt_q == LAST_STOP);
   assign pop       = can_pop && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_STOP) && last_stop && tick));

   always_ff @(posedge i_clk or posedge i_reset_w) begin
      if (i_reset_w) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  shift_q   <= i_fifo_data_w;
                  parity_q  <= parity_of(8'(i_fifo_data_w), PAR_MODE);
                  bit_cnt_q <= '0;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  tx_q    <= shift_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (bit_cnt_q == LAST_DATA) begin
                     bit_cnt_q <= '0;
                     if (PARITY_EN != 0) begin
                        tx_q    <= parity_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                     shift_q   <= shift_q >> 1;
                     tx_q      <= shift_q[1];
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  tx_q    <= 1'b1;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (last_stop && pre_tick) begin
                  done_q <= 1'b1;
               end
               if (tick) begin
                  if (!last_stop) begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                  end else if (pop) begin
                     shift_q   <= i_fifo_data_w;
                     parity_q  <= parity_of(8'(i_fifo_data_w), PAR_MODE);
                     bit_cnt_q <= '0;
                     tx_q      <= 1'b0;
                     state_q   <= ST_START;
                  end else begin
                     bit_cnt_q <= '0;
                     tx_q      <= 1'b1;
                     busy_q    <= 1'b0;
                     state_q   <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_fifo_read_w  = pop;
   assign o_tx_w         = tx_q;
   assign o_busy_w       = busy_q;
   assign o_frame_done_w = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (plain 8N1, even parity + 2 stop, odd parity)
// fed by queue-based FIFO models; dut0 frames are decoded and scored against pushed bytes.
module tb_uart_tx_ctrl;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] fd0, fd1, fd2;
   logic       fe0, fe1, fe2;
   logic [2:0] rd, tx, busy, done;

   logic [7:0] fq0[$];
   logic [7:0] fq1[$];
   logic [7:0] fq2[$];
   logic [7:0] exp_q[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .i_clk(clk), .i_reset_w(rst), .i_enable_w(en), .i_fifo_data_w(fd0), .i_fifo_empty_w(fe0),
      .o_fifo_read_w(rd[0]), .o_tx_w(tx[0]), .o_busy_w(busy[0]), .o_frame_done_w(done[0]));

   uart_tx_ctrl #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
      .i_clk(clk), .i_reset_w(rst), .i_enable_w(en), .i_fifo_data_w(fd1), .i_fifo_empty_w(fe1),
      .o_fifo_read_w(rd[1]), .o_tx_w(tx[1]), .o_busy_w(busy[1]), .o_frame_done_w(done[1]));

   uart_tx_ctrl #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
      .i_clk(clk), .i_reset_w(rst), .i_enable_w(en), .i_fifo_data_w(fd2), .i_fifo_empty_w(fe2),
      .o_fifo_read_w(rd[2]), .o_tx_w(tx[2]), .o_busy_w(busy[2]), .o_frame_done_w(done[2]));

   // FIFO models: the head is presented after each edge; a strobe seen at an edge pops.
   always @(posedge clk) begin
      if (rd[0]) begin
         total++;
         if (fq0.size() == 0) begin
            bad++;
            $display("[TB] FAIL pop_when_empty0: got pop strobe, required none (fifo empty)");
         end else fq0.delete(0);
      end
      fe0 <= (fq0.size() == 0);
      fd0 <= (fq0.size() != 0) ? fq0[0] : 8'h00;
   end

   always @(posedge clk) begin
      if (rd[1]) begin
         total++;
         if (fq1.size() == 0) begin
            bad++;
            $display("[TB] FAIL pop_when_empty1: got pop strobe, required none (fifo empty)");
         end else fq1.delete(0);
      end
      fe1 <= (fq1.size() == 0);
      fd1 <= (fq1.size() != 0) ? fq1[0] : 8'h00;
   end

   always @(posedge clk) begin
      if (rd[2]) begin
         total++;
         if (fq2.size() == 0) begin
            bad++;
            $display("[TB] FAIL pop_when_empty2: got pop strobe, required none (fifo empty)");
         end else fq2.delete(0);
      end
      fe2 <= (fq2.size() == 0);
      fd2 <= (fq2.size() != 0) ? fq2[0] : 8'h00;
   end

   // Line decoder for dut0: samples each bit mid-period and scores the byte and stop bit.
   bit         mon_act = 1'b0;
   int         mon_cyc;
   int         mon_bit;
   logic [7:0] mon_byte;
   logic [7:0] mon_exp;
   always @(negedge clk) begin
      if (rst) mon_act = 1'b0;
      else if (!mon_act) begin
         if (tx[0] === 1'b0) begin
            mon_act = 1'b1;
            mon_cyc = 0;
         end
      end else begin
         mon_cyc++;
         if (mon_cyc % CPB == CPB / 2) begin
            mon_bit = mon_cyc / CPB;
            if (mon_bit >= 1 && mon_bit <= 8) mon_byte = {tx[0], mon_byte[7:1]};
            else if (mon_bit == 9) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("[TB] FAIL unexpected_frame: got byte %h, required no frame", mon_byte);
               end else begin
                  mon_exp = exp_q.pop_front();
                  if ({tx[0], mon_byte} !== {1'b1, mon_exp}) begin
                     bad++;
                     $display("[TB] FAIL frame_byte: got stop=%b data=%h, required stop=1 data=%h",
                              tx[0], mon_byte, mon_exp);
                  end
               end
               mon_act = 1'b0;
            end
         end
      end
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int which, input logic [7:0] b, input bit scored);
      case (which)
         0:       fq0.push_back(b);
         1:       fq1.push_back(b);
         default: fq2.push_back(b);
      endcase
      if (scored) exp_q.push_back(b);
   endtask

   task automatic wait_pop(input int which, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (rd[which] === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic capture(input int which, input int n, output logic [127:0] txv,
                          output logic [127:0] busyv, output logic [127:0] donev, output int reads);
      txv = '0;
      busyv = '0;
      donev = '0;
      reads = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         txv[i]   = tx[which];
         busyv[i] = busy[which];
         donev[i] = done[which];
         if (rd[which] === 1'b1) reads++;
      end
   endtask

   function automatic void add_frame(inout logic [127:0] txv, inout logic [127:0] donev, inout int pos,
                                     input logic [7:0] b, input bit pe, input bit odd, input int stops);
      logic [11:0] fr;
      int nb;
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[i+1] = b[i];
      nb = 9;
      if (pe) begin
         fr[nb] = (^b) ^ odd;
         nb++;
      end
      nb += stops;
      for (int k = 0; k < nb * CPB; k++) txv[pos+k] = fr[k/CPB];
      pos += nb * CPB;
      donev[pos-1] = 1'b1;
   endfunction

   function automatic logic [127:0] ones(input int n);
      logic [127:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 3; w++) begin
         total++;
         if ({tx[w], busy[w], rd[w], done[w]} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reset_outputs dut%0d: got tx,busy,rd,done=%b, required 1000",
                     w, {tx[w], busy[w], rd[w], done[w]});
         end
      end
      rst = 1'b0;
      align();
   endtask

   task automatic test_idle_empty();
      logic [127:0] tv, bv, dv;
      int reads;
      align();
      en = 1'b1;
      capture(0, 100, tv, bv, dv, reads);
      total++;
      if (reads !== 0) begin
         bad++;
         $display("[TB] FAIL idle_no_pop: got %0d pops, required 0", reads);
      end
      total++;
      if (tv[99:0] !== ones(100)) begin
         bad++;
         $display("[TB] FAIL idle_line_high: got %h, required all ones", tv[99:0]);
      end
   endtask

   task automatic test_single();
      logic [127:0] tv, bv, dv, etv, edv;
      int reads, pos;
      bit ok;
      etv = '0; edv = '0; pos = 0;
      add_frame(etv, edv, pos, 8'hA5, 1'b0, 1'b0, 1);
      etv[pos] = 1'b1;
      align();
      push(0, 8'hA5, 1'b1);
      wait_pop(0, 10, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL single_pop: got no pop in 10 cycles, required one");
      end
      capture(0, 41, tv, bv, dv, reads);
      total++;
      if (tv !== etv) begin
         bad++;
         $display("[TB] FAIL single_wave: got %h, required %h", tv, etv);
      end
      total++;
      if (bv !== ones(40)) begin
         bad++;
         $display("[TB] FAIL single_busy: got %h, required %h", bv, ones(40));
      end
      total++;
      if (dv !== edv) begin
         bad++;
         $display("[TB] FAIL single_done: got %h, required %h", dv, edv);
      end
      total++;
      if (reads !== 0 || fq0.size() !== 0) begin
         bad++;
         $display("[TB] FAIL single_pop_count: got extra=%0d left=%0d, required 0 0", reads, fq0.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] tv, bv, dv, etv, edv;
      int reads, pos;
      bit ok;
      etv = '0; edv = '0; pos = 0;
      add_frame(etv, edv, pos, 8'h00, 1'b0, 1'b0, 1);
      add_frame(etv, edv, pos, 8'hFF, 1'b0, 1'b0, 1);
      add_frame(etv, edv, pos, 8'h3C, 1'b0, 1'b0, 1);
      etv[pos] = 1'b1;
      align();
      push(0, 8'h00, 1'b1);
      push(0, 8'hFF, 1'b1);
      push(0, 8'h3C, 1'b1);
      wait_pop(0, 10, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL b2b_first_pop: got no pop in 10 cycles, required one");
      end
      capture(0, 121, tv, bv, dv, reads);
      total++;
      if (tv !== etv) begin
         bad++;
         $display("[TB] FAIL b2b_wave: got %h, required %h", tv, etv);
      end
      total++;
      if (bv !== ones(120)) begin
         bad++;
         $display("[TB] FAIL b2b_busy: got %h, required %h", bv, ones(120));
      end
      total++;
      if (dv !== edv) begin
         bad++;
         $display("[TB] FAIL b2b_done: got %h, required %h", dv, edv);
      end
      total++;
      if (reads !== 2 || fq0.size() !== 0) begin
         bad++;
         $display("[TB] FAIL b2b_pops: got in-frame=%0d left=%0d, required 2 0", reads, fq0.size());
      end
   endtask

   task automatic test_parity();
      logic [127:0] tv, bv, dv, etv, edv;
      int reads, pos;
      bit ok;
      for (int w = 1; w < 3; w++) begin
         etv = '0; edv = '0; pos = 0;
         add_frame(etv, edv, pos, 8'h07, 1'b1, (w == 2), (w == 1) ? 2 : 1);
         etv[pos] = 1'b1;
         align();
         push(w, 8'h07, 1'b0);
         wait_pop(w, 10, ok);
         total++;
         if (!ok) begin
            bad++;
            $display("[TB] FAIL parity_pop dut%0d: got no pop in 10 cycles, required one", w);
         end
         capture(w, pos + 1, tv, bv, dv, reads);
         total++;
         if (tv[37] !== ((w == 1) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("[TB] FAIL parity_bit dut%0d: got %b, required %b", w, tv[37], (w == 1));
         end
         total++;
         if (tv !== etv) begin
            bad++;
            $display("[TB] FAIL parity_wave dut%0d: got %h, required %h", w, tv, etv);
         end
         total++;
         if (bv !== ones(pos) || dv !== edv) begin
            bad++;
            $display("[TB] FAIL parity_busy_done dut%0d: got busy=%h done=%h, required busy=%h done=%h",
                     w, bv, dv, ones(pos), edv);
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [127:0] tv, bv, dv;
      int reads;
      bit ok;
      align();
      en = 1'b0;
      push(0, 8'h96, 1'b1);
      push(0, 8'h4B, 1'b1);
      repeat (3) @(negedge clk);
      total++;
      if (fq0.size() !== 2) begin
         bad++;
         $display("[TB] FAIL disabled_no_pop: got fifo level %0d, required 2", fq0.size());
      end
      align();
      en = 1'b1;
      wait_pop(0, 10, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL drop_first_pop: got no pop in 10 cycles, required one");
      end
      repeat (18) @(negedge clk);
      #1;
      en = 1'b0;
      capture(0, 30, tv, bv, dv, reads);
      total++;
      if (reads !== 0 || fq0.size() !== 1) begin
         bad++;
         $display("[TB] FAIL drop_no_second_pop: got pops=%0d left=%0d, required 0 1", reads, fq0.size());
      end
      total++;
      if (bv[21:0] !== ones(22) || bv[29:22] !== 8'h00 || tv[29:22] !== 8'hFF) begin
         bad++;
         $display("[TB] FAIL drop_frame_completes: got busy=%h tx=%h, required busy=%h tx high from bit 22",
                  bv[29:0], tv[29:0], ones(22));
      end
      align();
      en = 1'b1;
      wait_pop(0, 10, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL reenable_pop: got no pop in 10 cycles, required one");
      end
      repeat (45) @(negedge clk);
      total++;
      if (fq0.size() !== 0 || busy[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reenable_done: got left=%0d busy=%b, required 0 0", fq0.size(), busy[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] tv, bv, dv;
      int reads;
      bit ok;
      align();
      en = 1'b1;
      push(0, 8'h5A, 1'b0);
      wait_pop(0, 10, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL midreset_pop: got no pop in 10 cycles, required one");
      end
      repeat (26) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({tx[0], busy[0]} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL midreset_async: got tx,busy=%b, required 10", {tx[0], busy[0]});
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      capture(0, 20, tv, bv, dv, reads);
      total++;
      if (reads !== 0 || tv[19:0] !== ones(20) || bv[19:0] !== 20'h0) begin
         bad++;
         $display("[TB] FAIL midreset_after: got pops=%0d tx=%h busy=%h, required 0 fffff 00000",
                  reads, tv[19:0], bv[19:0]);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_empty();
      test_single();
      test_back_to_back();
      test_parity();
      test_enable_drop();
      test_reset_mid();
      repeat (5) @(negedge clk);
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drained: got %0d frames outstanding, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
